fetch_unit: RTL and testbench

Instruction fetch front end sitting directly upstream of the FD latch of the 5-stage RISC-V pipeline. It owns the architectural fetch PC and issues in-order requests to a variable-latency instruction memory. Returned instructions are buffered together with their PC and branch-prediction metadata. Entries are handed to decode over a valid/ready handshake. On an EX redirect (mispredict or jump) it flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_WIDTH = 32;

    // One buffered fetch: the request PC, its prediction and the returned word.
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic                  pred_taken;
        logic [XLEN-1:0]       pred_target;
        logic [INST_WIDTH-1:0] inst;
        logic                  filled;
    } fetch_entry_t;

    // Width of a buffer pointer for a given entry count.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: imem request/response, predictor, redirect and decode handshakes.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [XLEN-1:0]       imem_req_addr;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_data;
    logic                  pred_taken;
    logic [XLEN-1:0]       pred_target;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [INST_WIDTH-1:0] dec_inst;
    logic [XLEN-1:0]       dec_pc;
    logic                  dec_pred_taken;
    logic [XLEN-1:0]       dec_pred_target;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  pred_taken, pred_target,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_inst, dec_pc, dec_pred_taken, dec_pred_target,
        input  dec_ready
    );

    // Memory / predictor / EX / decode side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output pred_taken, pred_target,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_inst, dec_pc, dec_pred_taken, dec_pred_target,
        output dec_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Fetch buffer: entries allocated at request time, filled in order by responses, popped to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc,
    input  fetch_entry_t          alloc_entry,
    input  logic                  fill,
    input  logic [INST_WIDTH-1:0] fill_inst,
    input  logic                  pop,
    output fetch_entry_t          head_entry
);

    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] tail;
    fetch_entry_t  entries [DEPTH];

    assign head_entry = entries[head];

    // Pointer and storage update; alloc, fill and pop never target the same slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                entries[tail] <= alloc_entry;
                tail          <= tail + PW'(1);
            end
            if (fill) begin
                entries[fill_ptr].inst   <= fill_inst;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PW'(1);
            end
            if (pop) begin
                entries[head].filled <= 1'b0;
                head                 <= head + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credited imem requests,
// buffers responses with prediction metadata and flushes on EX redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic          clock,
    input logic          reset,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = ptr_width(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   alloc_n;
    logic [CW-1:0]   pend_cnt;
    logic [CW-1:0]   pend_n;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_n;
    logic [CW-1:0]   outstanding;

    logic            credit;
    logic            req_fire;
    logic            resp_drop;
    logic            resp_fill;
    logic            pop;
    fetch_entry_t    alloc_entry;
    fetch_entry_t    head_entry;

    // Credit covers live buffer entries plus stale responses still owed by memory.
    assign credit    = (alloc_cnt + drop_cnt) < CW'(DEPTH);
    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_drop = bus.imem_resp_valid && (drop_cnt != '0);
    assign resp_fill = bus.imem_resp_valid && (drop_cnt == '0) && (pend_cnt != '0)
                       && !bus.redirect_valid;
    assign pop       = head_entry.filled && bus.dec_ready && !bus.redirect_valid;

    assign bus.imem_req_valid = credit && !bus.redirect_valid && !reset;
    assign bus.imem_req_addr  = pc;

    // Decode view of the head entry; zeroed while nothing is ready.
    assign bus.dec_valid       = head_entry.filled;
    assign bus.dec_inst        = head_entry.filled ? head_entry.inst        : '0;
    assign bus.dec_pc          = head_entry.filled ? head_entry.pc          : '0;
    assign bus.dec_pred_taken  = head_entry.filled && head_entry.pred_taken;
    assign bus.dec_pred_target = head_entry.filled ? head_entry.pred_target : '0;

    // New entry captured at request handshake; instruction arrives later.
    always_comb begin
        alloc_entry             = '0;
        alloc_entry.pc          = pc;
        alloc_entry.pred_taken  = bus.pred_taken;
        alloc_entry.pred_target = bus.pred_target;
    end

    // Next PC and counters; redirect overrides everything and turns pending fetches into drops.
    always_comb begin
        pc_n        = pc;
        alloc_n     = alloc_cnt;
        pend_n      = pend_cnt;
        drop_n      = drop_cnt;
        outstanding = drop_cnt + pend_cnt;
        if (bus.redirect_valid) begin
            pc_n    = bus.redirect_pc;
            alloc_n = '0;
            pend_n  = '0;
            drop_n  = outstanding - CW'(bus.imem_resp_valid && (outstanding != '0));
        end else begin
            alloc_n = alloc_cnt + CW'(req_fire) - CW'(pop);
            pend_n  = pend_cnt + CW'(req_fire) - CW'(resp_fill);
            drop_n  = drop_cnt - CW'(resp_drop);
            if (req_fire) begin
                pc_n = bus.pred_taken ? bus.pred_target : pc + XLEN'(4);
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            pc        <= pc_n;
            alloc_cnt <= alloc_n;
            pend_cnt  <= pend_n;
            drop_cnt  <= drop_n;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .flush       (bus.redirect_valid),
        .alloc       (req_fire),
        .alloc_entry (alloc_entry),
        .fill        (resp_fill),
        .fill_inst   (bus.imem_resp_data),
        .pop         (pop),
        .head_entry  (head_entry)
    );

    // A response with nothing outstanding and nothing to drop is a memory protocol error.
    resp_without_request: assert property (
        @(posedge clock) disable iff (reset)
        !(bus.imem_resp_valid && (drop_cnt == '0) && (pend_cnt == '0))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model and in-order memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if bus ();

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        bit          filled;
    } mentry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mentry_t     live[$];
    mreq_t       memq[$];
    int          stale;
    logic [31:0] mpc;
    int          last_due;
    int          cyc;

    int          lat_min, lat_max, p_ready, p_dec, p_pred, p_redir;
    bit          force_pred, force_redir;
    logic [31:0] force_tgt, force_pc;

    int          n_checks;
    int          n_fail;
    int          dut_fires;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        live.delete();
        memq.delete();
        stale    = 0;
        mpc      = RST_PC;
        last_due = 0;
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.pred_taken      = 1'b0;
        bus.pred_target     = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.dec_ready       = 1'b0;
    endtask

    // Assert reset mid-cycle, check outputs drop immediately, then release and clear the models.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("rst_dec_pc", bus.dec_pc, 32'd0);
        check("rst_dec_inst", bus.dec_inst, 32'd0);
        check("rst_req_addr", bus.imem_req_addr, RST_PC);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step();
        bit          resp;
        bit          exp_rv;
        bit          exp_dv;
        bit          fire;
        bit          popped;
        int          unf;
        int          lat;
        int          due;
        mentry_t     ne;
        mreq_t       nr;

        @(negedge clock);
        bus.imem_req_ready = ($urandom_range(99) < 32'(p_ready));
        bus.dec_ready      = ($urandom_range(99) < 32'(p_dec));
        bus.pred_taken     = force_pred || ($urandom_range(99) < 32'(p_pred));
        bus.pred_target    = force_pred ? force_tgt : ($urandom & 32'h0000_FFFC);
        bus.redirect_valid = force_redir || ($urandom_range(99) < 32'(p_redir));
        bus.redirect_pc    = force_redir ? force_pc : ($urandom & 32'h0000_FFFC);
        resp = (memq.size() > 0) && (memq[0].due <= cyc);
        bus.imem_resp_valid = resp;
        bus.imem_resp_data  = resp ? inst_of(memq[0].addr) : $urandom;
        if (resp) memq.delete(0);
        #1;

        exp_rv = !bus.redirect_valid && ((live.size() + stale) < int'(DEPTH));
        exp_dv = (live.size() > 0) && live[0].filled;

        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        check("req_addr", bus.imem_req_addr, mpc);
        check("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
        check("dec_pc", bus.dec_pc, exp_dv ? live[0].pc : 32'd0);
        check("dec_inst", bus.dec_inst, exp_dv ? inst_of(live[0].pc) : 32'd0);
        check("dec_pred_taken", 32'(bus.dec_pred_taken), exp_dv ? 32'(live[0].pt) : 32'd0);
        check("dec_pred_target", bus.dec_pred_target, exp_dv ? live[0].ptgt : 32'd0);

        if (bus.imem_req_valid && bus.imem_req_ready) dut_fires++;

        fire   = exp_rv && bus.imem_req_ready;
        popped = exp_dv && bus.dec_ready;

        if (fire) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            nr.addr  = mpc;
            nr.due   = due;
            memq.push_back(nr);
        end

        if (bus.redirect_valid) begin
            unf = 0;
            foreach (live[i]) if (!live[i].filled) unf++;
            stale += unf;
            if (resp && stale > 0) stale--;
            live.delete();
            mpc = bus.redirect_pc;
        end else begin
            if (resp) begin
                if (stale > 0) begin
                    stale--;
                end else begin
                    for (int i = 0; i < live.size(); i++) begin
                        if (!live[i].filled) begin
                            live[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (popped) live.delete(0);
            if (fire) begin
                ne.pc     = mpc;
                ne.pt     = bus.pred_taken;
                ne.ptgt   = bus.pred_target;
                ne.filled = 1'b0;
                live.push_back(ne);
                mpc = bus.pred_taken ? bus.pred_target : mpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic knobs(input int lmin, input int lmax, input int pr, input int pd,
                         input int pp, input int pre);
        lat_min = lmin; lat_max = lmax; p_ready = pr; p_dec = pd; p_pred = pp; p_redir = pre;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        dut_fires   = 0;
        cyc         = 0;
        force_pred  = 1'b0;
        force_redir = 1'b0;
        force_tgt   = '0;
        force_pc    = '0;
        idle_inputs();
        model_reset();
        knobs(1, 1, 100, 100, 0, 0);
        do_reset();

        // Straight-line streaming at one instruction per cycle.
        knobs(1, 1, 100, 100, 0, 0);
        run(20);

        // Decode stalled from reset: buffer fills to DEPTH requests, then drains in order.
        do_reset();
        knobs(1, 1, 100, 0, 0, 0);
        dut_fires = 0;
        run(10);
        check("full_req_count", 32'(dut_fires), 32'(DEPTH));
        knobs(1, 1, 100, 100, 0, 0);
        run(10);

        // Taken prediction steers the next request and is carried to decode.
        force_pred = 1'b1;
        force_tgt  = 32'h0000_0100;
        step();
        force_pred = 1'b0;
        run(8);

        // Long-latency memory with a redirect while requests are in flight.
        knobs(5, 5, 100, 100, 0, 0);
        run(3);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0200;
        step();
        force_redir = 1'b0;
        run(20);

        // Redirect in steady state, coinciding with a response and a pop.
        knobs(1, 1, 100, 100, 0, 0);
        run(6);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0300;
        step();
        force_redir = 1'b0;
        run(6);

        // Reset with entries buffered and requests outstanding.
        knobs(2, 2, 100, 0, 0, 0);
        run(4);
        do_reset();
        knobs(1, 1, 100, 100, 0, 0);
        run(10);

        // Randomized traffic with occasional mid-run resets.
        for (int r = 0; r < 3; r++) begin
            knobs(1, 6, 70, 70, 15, 4);
            run(1000);
            knobs(1, 6, 90, 20, 15, 0);
            run(200);
            do_reset();
        end
        knobs(1, 3, 100, 100, 10, 2);
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
